// File: rtl/sine_pkg.sv
// Shared defaults, the unity-gain constant and the quadrant encoding for the
// phase-to-sine datapath.
package sine_pkg;

    localparam int PHASE_W_DEF = 32;
    localparam int ADDR_W_DEF  = 8;
    localparam int OUT_W_DEF   = 16;
    localparam int AMP_W_DEF   = 16;

    localparam logic [AMP_W_DEF-1:0] AMP_UNITY = 16'h8000;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_e;

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine magnitude table, synchronous read with one cycle of latency.
// Entry k holds round(FULL * sin(pi/2 * (k + 0.5) / DEPTH)).
module quarter_sine_rom
    import sine_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = OUT_W_DEF
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Evaluated at elaboration only; the Taylor series converges to double precision.
    function automatic logic [DEPTH*DATA_W-1:0] build_table();
        logic [DEPTH*DATA_W-1:0] tbl;
        real x, term, s, full;
        tbl  = '0;
        full = real'((2 ** (DATA_W - 1)) - 1);
        for (int k = 0; k < DEPTH; k++) begin
            x    = 1.57079632679489661923 * (real'(k) + 0.5) / real'(DEPTH);
            term = x;
            s    = 0.0;
            for (int n = 0; n < 12; n++) begin
                s    = s + term;
                term = -term * x * x / real'((2 * n + 2) * (2 * n + 3));
            end
            tbl[k*DATA_W +: DATA_W] = DATA_W'($rtoi(full * s + 0.5));
        end
        return tbl;
    endfunction

    localparam logic [DEPTH*DATA_W-1:0] TABLE = build_table();

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            data_q <= TABLE[addr_i*DATA_W +: DATA_W];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/phase_to_sine.sv
// Phase word to scaled signed sine sample: quadrant decode, quarter-wave lookup,
// sign and amplitude scaling, in a three-stage pipeline with a global stall.
module phase_to_sine
    import sine_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int AMP_W   = AMP_W_DEF
) (
    input  logic                    CLK,
    input  logic                    SCLR,
    input  logic [PHASE_W-1:0]      phase_in,
    input  logic                    phase_valid,
    output logic                    phase_ready,
    input  logic [AMP_W-1:0]        amplitude,
    output logic signed [OUT_W-1:0] sine_out,
    output logic                    sine_valid,
    input  logic                    sine_ready
);

    localparam logic [AMP_W-1:0] UNITY = AMP_W'(AMP_UNITY);
    localparam int PROD_W = OUT_W + AMP_W + 1;

    function automatic logic [AMP_W-1:0] clamp_amp(input logic [AMP_W-1:0] a);
        return (a > UNITY) ? UNITY : a;
    endfunction

    logic                     adv;
    logic                     vld_p0_q, vld_p1_q, vld_p2_q;
    quadrant_e                quad_p0_q, quad_p1_q;
    logic [ADDR_W-1:0]        idx_p0_q;
    logic [AMP_W-1:0]         amp_p0_q, amp_p1_q;
    logic [ADDR_W-1:0]        rom_addr_p0;
    logic [OUT_W-1:0]         mag_p1;
    logic signed [OUT_W-1:0]  raw_p1;
    logic signed [PROD_W-1:0] raw_x_p1, amp_x_p1, prod_p1;
    logic signed [OUT_W-1:0]  sine_d, sine_q;

    // Every stage moves together; only a held output with no taker stops the pipe.
    assign adv         = !(vld_p2_q && !sine_ready);
    assign phase_ready = adv;

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            sine_q   <= '0;
        end else if (adv) begin
            vld_p0_q <= phase_valid;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                sine_q <= sine_d;
            end
        end
    end

    // ---- S1: capture quadrant, table index and clamped gain ----
    always_ff @(posedge CLK) begin
        if (adv) begin
            quad_p0_q <= quadrant_e'(phase_in[PHASE_W-1 -: 2]);
            idx_p0_q  <= phase_in[PHASE_W-3 -: ADDR_W];
            amp_p0_q  <= clamp_amp(amplitude);
            quad_p1_q <= quad_p0_q;
            amp_p1_q  <= amp_p0_q;
        end
    end

    // ---- S2: table read; odd quadrants walk the quarter wave backwards ----
    assign rom_addr_p0 = (quad_p0_q == QUAD_1 || quad_p0_q == QUAD_3) ? ~idx_p0_q : idx_p0_q;

    quarter_sine_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (OUT_W)
    ) u_rom (
        .clk_i  (CLK),
        .en_i   (adv),
        .addr_i (rom_addr_p0),
        .data_o (mag_p1)
    );

    // ---- S3: sign, gain multiply and floor shift into the output register ----
    always_comb begin
        raw_p1 = $signed(mag_p1);
        if (quad_p1_q inside {QUAD_2, QUAD_3}) begin
            raw_p1 = -$signed(mag_p1);
        end
        raw_x_p1 = PROD_W'(raw_p1);
        amp_x_p1 = PROD_W'({1'b0, amp_p1_q});
        prod_p1  = raw_x_p1 * amp_x_p1;
        sine_d   = prod_p1[AMP_W-1 +: OUT_W];
    end

    logic unused_bits;
    assign unused_bits = ^{phase_in[PHASE_W-3-ADDR_W:0],
                           prod_p1[PROD_W-1:AMP_W-1+OUT_W],
                           prod_p1[AMP_W-2:0]};

    assign sine_out   = sine_q;
    assign sine_valid = vld_p2_q;

endmodule

// File: doc/phase_to_sine.md
PHASE_TO_SINE -- requirements
Module: phase_to_sine

Interface
REQ-001 SHALL have parameter PHASE_W, default 32, phase word width (matches phase counter output).
REQ-002 SHALL have parameter ADDR_W, default 8, quarter-wave table address width (256 entries).
REQ-003 SHALL have parameter OUT_W, default 16, signed sample width.
REQ-004 SHALL have parameter AMP_W, default 16, amplitude width, unsigned Q1.15.
REQ-005 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-006 SHALL have port SCLR  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port phase_in  input  PHASE_W  phase word from the phase counter.
REQ-008 SHALL have port phase_valid  input  1  phase_in is valid this cycle.
REQ-009 SHALL have port phase_ready  output  1  block accepts phase_in this cycle.
REQ-010 SHALL have port amplitude  input  AMP_W  gain, 0x8000 = unity; sampled together with phase_in.
REQ-011 SHALL have port sine_out  output  OUT_W  signed two's-complement sample.
REQ-012 SHALL have port sine_valid  output  1  sine_out is valid.
REQ-013 SHALL have port sine_ready  input  1  downstream accepts sine_out.

Function
REQ-014 SHALL decode quadrant q = phase_in[31:30] and index idx = phase_in[29:22]; lower phase bits are discarded.
REQ-015 SHALL hold a 256-entry quarter table, entry k = round(32767 * sin(pi/2 * (k+0.5)/256)), all values positive, max 32767.
REQ-016 SHALL form raw sample: q0 -> +T[idx]; q1 -> +T[~idx]; q2 -> -T[idx]; q3 -> -T[~idx].
REQ-017 SHALL clamp amplitude above 0x8000 to 0x8000 before use.
REQ-018 SHALL compute sine_out = (raw * amp) arithmetic-shifted right by 15 (floor, no rounding); result always fits OUT_W.
REQ-019 SHALL be a 3-stage pipeline: S1 register q/idx/amp; S2 synchronous table read; S3 negate, multiply, shift, register output.
REQ-020 SHALL present the result 3 cycles after acceptance when sine_ready stays high; throughput one sample per cycle.
REQ-021 SHALL accept a phase word on a cycle where phase_valid && phase_ready.
REQ-022 SHALL drive phase_ready = !(sine_valid && !sine_ready) (global stall).
REQ-023 SHALL freeze all pipeline stages, valid bits and sine_out while stalled; no sample lost or duplicated.
REQ-024 SHALL propagate a per-stage valid bit; bubbles (phase_valid low) travel as invalid stages.
REQ-025 SHALL keep sine_out stable while sine_valid && !sine_ready.

Reset
REQ-026 SHALL, on SCLR high at a rising CLK edge, clear all stage valid bits and set sine_out to 0.
REQ-027 SHALL drop in-flight samples when SCLR asserts mid-stream; first output after release follows first accepted phase by 3 cycles.
REQ-028 SHALL hold phase_ready high during and after reset (sine_valid is 0).

Structure
REQ-029 SHALL place PHASE_W, ADDR_W, OUT_W, AMP_W defaults, unity constant 0x8000 and quadrant enum in shared package sine_pkg.
REQ-030 SHALL implement the table as sub-module quarter_sine_rom (synchronous read, 1-cycle latency, read-enable tied to stage advance).

Verification
REQ-031 SHALL test phase 0x00000000, 0x40000000, 0x80000000, 0xC0000000, amp 0x8000, sine_ready=1 -> outputs 101, 32767, -101, -32767, each 3 cycles after input.
REQ-032 SHALL test phase 0x40000000 with amp 0x4000 -> 16383; phase 0xC0000000 with amp 0x4000 -> -16384; amp 0xFFFF -> same as 0x8000.
REQ-033 SHALL test continuous phase stream with sine_ready low for 5 cycles mid-stream -> phase_ready low those cycles, output sequence identical to unstalled run.
REQ-034 SHALL test SCLR asserted with 2 samples in flight -> sine_valid 0 next cycle, sine_out 0, no stale samples emitted after release.
REQ-035 SHALL test full sweep with phase counter increment 0x00400000 (1024 samples/period) -> sine_out odd-symmetric, |sample| <= 32767, matches reference model bit-exactly.
